// File: rtl/sipo_deser_if.sv
// rtl/sipo_deser_if.sv - bit-strobe input and parallel-word output bundle for sipo_deser
interface sipo_deser_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic          En;
    logic          Din;
    logic [WIDTH-1:0] Dout;
    logic          Valid;
    logic          Busy;
    logic [CW-1:0] Cnt;

    // master is the serial source side, slave is the deserializer
    modport master (
        output En, Din,
        input  Dout, Valid, Busy, Cnt
    );

    modport slave (
        input  En, Din,
        output Dout, Valid, Busy, Cnt
    );
endinterface

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in/parallel-out deserializer with async Ra and sync Rs clears
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk0,
    input  logic        Ra,
    input  logic        Rs,
    sipo_deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {sr_q[WIDTH-2:0], bus.Din};
        end else begin
            shifted = {bus.Din, sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        if (Rs) begin
            state_d = IDLE;
            sr_d    = '0;
            cnt_d   = '0;
            dout_d  = '0;
        end else if (bus.En) begin
            sr_d = shifted;
            // completing edge publishes the word including the bit sampled now
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                dout_d  = shifted;
                valid_d = 1'b1;
            end else begin
                state_d = SHIFT;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk0 or posedge Ra) begin
        if (Ra) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Dout  = dout_q;
    assign bus.Valid = valid_q;
    assign bus.Cnt   = cnt_q;
    assign bus.Busy  = (cnt_q != '0);
endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - directed self-checking bench for sipo_deser in both bit orders
module tb_sipo_deser;
    logic clk0 = 1'b0;
    logic Ra   = 1'b0;
    logic Rs   = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk0 = ~clk0;

    sipo_deser_if #(.WIDTH(8)) bm ();
    sipo_deser_if #(.WIDTH(8)) bl ();

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk0 (clk0),
        .Ra   (Ra),
        .Rs   (Rs),
        .bus  (bm.slave)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk0 (clk0),
        .Ra   (Ra),
        .Rs   (Rs),
        .bus  (bl.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic din);
        bm.En  = en;
        bm.Din = din;
        bl.En  = en;
        bl.Din = din;
    endtask

    task automatic step(input logic en, input logic din, input logic rs);
        @(negedge clk0);
        drive(en, din);
        Rs = rs;
        @(posedge clk0);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_dout_m"}, bm.Dout, 0);
        check({tag, "_dout_l"}, bl.Dout, 0);
        check({tag, "_cnt_m"}, bm.Cnt, 0);
        check({tag, "_cnt_l"}, bl.Cnt, 0);
        check({tag, "_busy_m"}, bm.Busy, 0);
        check({tag, "_valid_m"}, bm.Valid, 0);
        check({tag, "_valid_l"}, bl.Valid, 0);
    endtask

    // streams w msb-first; wl is the word the lsb-first instance must build
    task automatic send_word(input logic [7:0] w, input logic [7:0] wl,
                             input logic [7:0] prev_m, input logic [7:0] prev_l);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, w[i], 1'b0);
            if (i != 0) begin
                check("cnt_m", bm.Cnt, 32'(8 - i));
                check("cnt_l", bl.Cnt, 32'(8 - i));
                check("busy_m", bm.Busy, 1);
                check("valid_m", bm.Valid, 0);
                check("valid_l", bl.Valid, 0);
                check("hold_m", bm.Dout, prev_m);
                check("hold_l", bl.Dout, prev_l);
            end else begin
                check("wcnt_m", bm.Cnt, 0);
                check("wbusy_m", bm.Busy, 0);
                check("wvalid_m", bm.Valid, 1);
                check("wvalid_l", bl.Valid, 1);
                check("word_m", bm.Dout, w);
                check("word_l", bl.Dout, wl);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] gap_bits;
        drive(1'b0, 1'b0);
        #1 Ra = 1'b1;
        #1 check_cleared("rst");
        drive(1'b1, 1'b1);
        @(posedge clk0);
        #1 check_cleared("rst_hold");
        @(negedge clk0);
        drive(1'b0, 1'b0);
        Ra = 1'b0;

        // 1,0,1,1,0,0,1,0 -> B2 msb-first, 4D lsb-first
        send_word(8'hB2, 8'h4D, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0);
        check("post_valid_m", bm.Valid, 0);
        check("post_dout_m", bm.Dout, 8'hB2);
        check("post_dout_l", bl.Dout, 8'h4D);

        // same word with a three-cycle En gap after bit 4
        gap_bits = 8'hB2;
        for (int i = 7; i >= 4; i--) step(1'b1, gap_bits[i], 1'b0);
        check("gap_cnt", bm.Cnt, 4);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0);
            check("gap_hold_cnt", bm.Cnt, 4);
            check("gap_busy", bm.Busy, 1);
            check("gap_valid", bm.Valid, 0);
        end
        for (int i = 3; i >= 1; i--) begin
            step(1'b1, gap_bits[i], 1'b0);
            check("gap_tail_valid", bm.Valid, 0);
        end
        step(1'b1, gap_bits[0], 1'b0);
        check("gap_valid_m", bm.Valid, 1);
        check("gap_word_m", bm.Dout, 8'hB2);
        check("gap_word_l", bl.Dout, 8'h4D);

        // sync clear mid-word, En/Din on the clear edge ignored
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
        check("pre_rs_cnt", bm.Cnt, 3);
        step(1'b1, 1'b1, 1'b1);
        check_cleared("rs");
        send_word(8'hFF, 8'hFF, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0);
        check("ff_single_valid", bm.Valid, 0);

        // back-to-back words with continuous En
        send_word(8'hA5, 8'hA5, 8'hFF, 8'hFF);
        send_word(8'h3C, 8'h3C, 8'hA5, 8'hA5);

        // async reset between edges mid-word
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("pre_ra_cnt", bm.Cnt, 3);
        check("pre_ra_dout", bm.Dout, 8'h3C);
        @(negedge clk0);
        #2 Ra = 1'b1;
        #1 check_cleared("ra_async");
        @(posedge clk0);
        #1 check_cleared("ra_held");
        #2 Ra = 1'b0;
        send_word(8'hB2, 8'h4D, 8'h00, 8'h00);

        // sync clear on the completing edge suppresses Valid
        for (int i = 7; i >= 1; i--) step(1'b1, gap_bits[i], 1'b0);
        check("pre_rsw_cnt", bm.Cnt, 7);
        step(1'b1, gap_bits[0], 1'b1);
        check_cleared("rs_complete");
        step(1'b0, 1'b0, 1'b0);
        check("rs_complete_novalid", bm.Valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in/parallel-out deserializer that sits directly downstream of the `xDFF` flip-flop stage. It consumes the registered serial bit stream on `xDFF`'s `Q0` and assembles `WIDTH` qualified bits into a parallel word. It reports completion with a one-cycle `Valid` pulse, and supports the same async/sync clear scheme as `xDFF`: asynchronous `Ra`, synchronous `Rs`.

## Interface
Parameters:
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `MSB_FIRST`, default 1:
  - 1: the first received bit lands in `Dout[WIDTH-1]`.
  - 0: the first received bit lands in `Dout[0]`.

Ports:
- `clk0`  in  1  single clock; all state updates on its rising edge.
- `Ra`  in  1  asynchronous, active-high reset; clears all state immediately.
- `Rs`  in  1  synchronous clear, active-high; takes effect at the next rising edge of `clk0`.
- `En`  in  1  bit strobe; `Din` is sampled only on edges where `En`=1.
- `Din`  in  1  serial data bit; driven by `xDFF` `Q0`.
- `Dout`  out  `WIDTH`  last completed word; held until the next word completes.
- `Valid`  out  1  one-cycle pulse; asserted in the cycle after the word-completing edge.
- `Busy`  out  1  high while a partial word is held (`Cnt` != 0).
- `Cnt`  out  `$clog2(WIDTH)`  number of bits collected in the current partial word.

## Operation
- Internal state: shift register `sr[WIDTH-1:0]`, bit counter `Cnt`, and a two-state FSM.
  - IDLE: `Cnt`=0.
  - SHIFT: 0 < `Cnt` < `WIDTH`.
- Shift direction:
  - `MSB_FIRST`=1: `sr <= {sr[WIDTH-2:0], Din}`.
  - `MSB_FIRST`=0: `sr <= {Din, sr[WIDTH-1:1]}`.
- Edge with `En`=1 and `Cnt` < `WIDTH-1`: shift, `Cnt` += 1. IDLE→SHIFT on the first bit.
- Edge with `En`=1 and `Cnt` == `WIDTH-1` (word-completing edge):
  - `Dout` <= the shifted value including the current `Din`.
  - `Valid` <= 1, `Cnt` <= 0, FSM → IDLE.
  - `sr` holds the completed word; it is overwritten bit by bit by the next word.
- Edge with `En`=0: `sr`, `Cnt` and `Dout` hold; `Valid` <= 0.
- `Valid` is registered and high for exactly one cycle per completed word. It is deasserted on every edge that does not complete a word.
- `Busy` = (`Cnt` != 0), combinational from `Cnt`.
- Priority, highest first: `Ra` > `Rs` > `En`.
- `Rs`=1 at an edge:
  - `sr`, `Cnt`, `Dout` and `Valid` all cleared to 0; FSM → IDLE.
  - `Din`/`En` on that edge are ignored.
- `Ra`=1: all registers cleared to 0 asynchronously and held there while `Ra` stays high.
- Counter wrap: `Cnt` never reaches `WIDTH`; it returns to 0 on the completing edge.

## Timing
- Reset values, after `Ra` or `Rs`: `Dout`=0, `Valid`=0, `Busy`=0, `Cnt`=0.
- Latency: `Valid` and the new `Dout` are both visible one clock after the edge that samples the `WIDTH`-th bit.
- Back-to-back words with `En` held high: `Valid` pulses every `WIDTH` cycles, with no dead cycle between words.
- The first bit of the next word may be sampled on the edge immediately after a completing edge. The completed `Dout` remains stable until the following completion.
- `Ra` deassertion: the first sampling edge is the first rising `clk0` edge with `Ra`=0.
- `Ra` asserted mid-word: the partial word is discarded, no `Valid` is generated, and `Dout` reads 0.
- `Rs` asserted on a word-completing edge: the clear wins, and no `Valid` is generated.
- `Din` must be stable around the `clk0` rising edge. `xDFF` `Q0` on the same `clk0` meets this by construction.

## Test plan
- `WIDTH`=8, `MSB_FIRST`=1, `En`=1, `Din` sequence 1,0,1,1,0,0,1,0 → `Dout`=8'hB2; `Valid` high exactly one cycle after the 8th edge; `Cnt` steps 1..7 then 0.
- Same bit sequence with `MSB_FIRST`=0 → `Dout`=8'h4D, `Valid` pulse at the same cycle.
- Same sequence with `En`=0 inserted for 3 cycles after bit 4 → `Dout`=8'hB2; `Valid` delayed by 3 cycles; `Cnt` holds at 4 during the gap.
- 3 bits in, then `Rs`=1 for one edge → `Cnt`=0, `Busy`=0, `Dout`=0. Next 8 bits 0xFF form word 8'hFF with a single `Valid`.
- Two words 8'hA5 and 8'h3C streamed with continuous `En` → two `Valid` pulses exactly 8 cycles apart; `Dout`=8'hA5 and then 8'h3C.
- `Ra` pulsed asynchronously between clock edges mid-word → all outputs go to 0 before the next edge, and no `Valid` is generated for the partial word.
